// File: rtl/irq_ctrl_if.sv
// Word-addressed peripheral bus shared with the timer block.
// The master drives address, strobe, write enable and write data; the slave returns read data.
interface irq_ctrl_if;
   logic [3:0]  add;
   logic        stb;
   logic        we;
   logic [31:0] dat_i;
   logic [31:0] dat_o;

   modport master (output add, stb, we, dat_i, input dat_o);
   modport slave  (input add, stb, we, dat_i, output dat_o);
endinterface

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: pending/mask/edge registers, lowest-index priority,
// and a request/ack/EOI handshake. Optional IRQ_CTRL_SYNC_EN adds a 2-flop input synchronizer.
module irq_ctrl #(
   parameter int unsigned N_IRQ = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   irq_ctrl_if.slave        bus,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             int_ack,
   output logic             irq,
   output logic [4:0]       int_id
);

   localparam int unsigned ID_W = 5;
   localparam logic [3:0] ADDR_PEND   = 4'd0;
   localparam logic [3:0] ADDR_MASK   = 4'd1;
   localparam logic [3:0] ADDR_EDGE   = 4'd2;
   localparam logic [3:0] ADDR_CLEAR  = 4'd3;
   localparam logic [3:0] ADDR_CTRL   = 4'd4;
   localparam logic [3:0] ADDR_VECTOR = 4'd5;
   localparam logic [3:0] ADDR_EOI    = 4'd6;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t           state_q;
   logic [N_IRQ-1:0] pend_q, mask_q, edge_q, prev_q;
   logic             gie_q;

   logic [N_IRQ-1:0] irq_s;
   logic [N_IRQ-1:0] eligible_c, rise_c, clr_c, ack_clr_c, pend_nxt_c;
   logic [ID_W-1:0]  winner_c;
   logic [31:0]      rdata_c;
   logic             wr_c, ack_fire_c;
   logic             unused_dat_c;

`ifdef IRQ_CTRL_SYNC_EN
   logic [N_IRQ-1:0] sync_q1, sync_q2;

   // Two-flop synchronizer for asynchronous request sources
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq_in;
         sync_q2 <= sync_q1;
      end
   end
   assign irq_s = sync_q2;
`else
   assign irq_s = irq_in;
`endif

   assign wr_c         = bus.stb && bus.we;
   assign ack_fire_c   = (state_q == REQ) && int_ack;
   assign eligible_c   = gie_q ? (pend_q & mask_q) : '0;
   assign rise_c       = irq_s & ~prev_q;
   assign clr_c        = (wr_c && bus.add == ADDR_CLEAR) ? bus.dat_i[N_IRQ-1:0] : '0;
   assign unused_dat_c = ^bus.dat_i;

   // Lowest index wins
   always_comb begin
      winner_c = '0;
      for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
         if (eligible_c[i]) winner_c = ID_W'(i);
      end
   end

   // Acknowledge retires the in-flight ID; an edge set in the same cycle still wins
   always_comb begin
      ack_clr_c = '0;
      for (int i = 0; i < int'(N_IRQ); i++) begin
         ack_clr_c[i] = ack_fire_c && (int_id == ID_W'(i));
      end
      pend_nxt_c = (edge_q & (rise_c | (pend_q & ~clr_c & ~ack_clr_c)))
                 | (~edge_q & irq_s);
   end

   always_comb begin
      rdata_c = '0;
      case (bus.add)
         ADDR_PEND:   rdata_c = 32'(pend_q);
         ADDR_MASK:   rdata_c = 32'(mask_q);
         ADDR_EDGE:   rdata_c = 32'(edge_q);
         ADDR_CTRL:   rdata_c = 32'(gie_q);
         ADDR_VECTOR: rdata_c = {irq || (state_q == SERVICE), 26'b0, int_id};
         default:     rdata_c = '0;
      endcase
   end
   assign bus.dat_o = rdata_c;

   // Source registers and software-visible configuration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         prev_q <= '0;
         mask_q <= '0;
         edge_q <= '0;
         gie_q  <= 1'b0;
      end else begin
         pend_q <= pend_nxt_c;
         prev_q <= irq_s;
         if (wr_c && bus.add == ADDR_MASK) mask_q <= bus.dat_i[N_IRQ-1:0];
         if (wr_c && bus.add == ADDR_EDGE) edge_q <= bus.dat_i[N_IRQ-1:0];
         if (wr_c && bus.add == ADDR_CTRL) gie_q  <= bus.dat_i[0];
      end
   end

   // Request / acknowledge / end-of-interrupt handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         irq     <= 1'b0;
         int_id  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|eligible_c) begin
                  state_q <= REQ;
                  irq     <= 1'b1;
                  int_id  <= winner_c;
               end
            end
            REQ: begin
               if (int_ack) begin
                  state_q <= SERVICE;
                  irq     <= 1'b0;
               end else if (!(|eligible_c)) begin
                  state_q <= IDLE;
                  irq     <= 1'b0;
               end else begin
                  int_id  <= winner_c;
               end
            end
            SERVICE: begin
               if (wr_c && bus.add == ADDR_EOI) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               irq     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic against a per-source reference model.
module tb_irq_ctrl;
   localparam int unsigned N = 8;
`ifdef IRQ_CTRL_SYNC_EN
   localparam int LX = 2;
`else
   localparam int LX = 0;
`endif
   localparam int M_IDLE = 0, M_WAIT = 1, M_SERV = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] irq_in;
   logic         int_ack;
   logic         irq;
   logic [4:0]   int_id;

   irq_ctrl_if bus();

   irq_ctrl #(.N_IRQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .irq_in(irq_in), .int_ack(int_ack), .irq(irq), .int_id(int_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one entry per source, controller mode as a small integer
   bit m_pend [N];
   bit m_mask [N];
   bit m_edge [N];
   bit m_prev [N];
   bit m_sy1  [N];
   bit m_sy2  [N];
   bit m_gie;
   bit m_irq;
   int m_id;
   int m_mode;

   function automatic void m_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = 0;
         m_prev[i] = 0; m_sy1[i] = 0;  m_sy2[i] = 0;
      end
      m_gie = 0; m_irq = 0; m_id = 0; m_mode = M_IDLE;
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] a);
      logic [31:0] v = 0;
      for (int i = 0; i < N; i++) begin
         if (a == 0 && m_pend[i]) v = v + (32'd1 << i);
         if (a == 1 && m_mask[i]) v = v + (32'd1 << i);
         if (a == 2 && m_edge[i]) v = v + (32'd1 << i);
      end
      if (a == 4) v = 32'(m_gie);
      if (a == 5) v = ((m_irq || m_mode == M_SERV) ? 32'h8000_0000 : 32'd0) + 32'(m_id);
      return v;
   endfunction

   function automatic void m_step(input logic [N-1:0] in_v, input logic ack_v, input logic wr_v,
                                  input logic [3:0] a, input logic [31:0] d);
      bit s [N];
      int win = -1;
      bit ack_fire = 0;
      for (int i = 0; i < N; i++) begin
`ifdef IRQ_CTRL_SYNC_EN
         s[i] = m_sy2[i]; m_sy2[i] = m_sy1[i]; m_sy1[i] = in_v[i];
`else
         s[i] = in_v[i];
`endif
      end
      for (int i = 0; i < N; i++)
         if (win < 0 && m_gie && m_pend[i] && m_mask[i]) win = i;
      case (m_mode)
         M_IDLE: if (win >= 0) begin m_mode = M_WAIT; m_irq = 1; m_id = win; end
         M_WAIT: begin
            if (ack_v) begin m_mode = M_SERV; m_irq = 0; ack_fire = 1; end
            else if (win < 0) begin m_mode = M_IDLE; m_irq = 0; end
            else m_id = win;
         end
         default: if (wr_v && a == 6) m_mode = M_IDLE;
      endcase
      for (int i = 0; i < N; i++) begin
         if (!m_edge[i]) m_pend[i] = s[i];
         else if (s[i] && !m_prev[i]) m_pend[i] = 1;
         else if ((wr_v && a == 3 && d[i]) || (ack_fire && m_id == i)) m_pend[i] = 0;
         m_prev[i] = s[i];
      end
      if (wr_v && a == 1) for (int i = 0; i < N; i++) m_mask[i] = d[i];
      if (wr_v && a == 2) for (int i = 0; i < N; i++) m_edge[i] = d[i];
      if (wr_v && a == 4) m_gie = d[0];
   endfunction

   // One clock: drive just after a falling edge, check read data, clock, check outputs
   task automatic step(input logic [N-1:0] in_v, input logic ack_v, input logic stb_v,
                       input logic we_v, input logic [3:0] a, input logic [31:0] d);
      irq_in = in_v; int_ack = ack_v; bus.stb = stb_v; bus.we = we_v; bus.add = a; bus.dat_i = d;
      #1 check("dat_o", bus.dat_o, m_read(a));
      @(posedge clk);
      m_step(in_v, ack_v, stb_v && we_v, a, d);
      @(negedge clk);
      check("irq", 32'(irq), 32'(m_irq));
      check("int_id", 32'(int_id), 32'(m_id));
   endtask

   task automatic hold(input logic [N-1:0] v, input logic [3:0] a);
      step(v, 1'b0, 1'b0, 1'b0, a, 32'd0);
   endtask

   task automatic wr(input logic [N-1:0] v, input logic [3:0] a, input logic [31:0] d);
      step(v, 1'b0, 1'b1, 1'b1, a, d);
   endtask

   task automatic ack(input logic [N-1:0] v, input logic [3:0] a);
      step(v, 1'b1, 1'b0, 1'b0, a, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] cur_in;
      logic [3:0]   ra;
      logic [31:0]  rd;
      rst_n = 1'b0; irq_in = '0; int_ack = 1'b0;
      bus.add = '0; bus.stb = 1'b0; bus.we = 1'b0; bus.dat_i = '0;
      m_reset();
      repeat (2) @(negedge clk);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_id", 32'(int_id), 32'd0);
      rst_n = 1'b1;

      wr('0, 4'd1, 32'hFF);
      wr('0, 4'd4, 32'h1);

      // Level source 1 held high
      hold(8'h02, 4'd0); hold(8'h02, 4'd0); repeat (LX) hold(8'h02, 4'd0);
      check("lvl_irq", 32'(irq), 32'd1);
      check("lvl_id", 32'(int_id), 32'd1);
      ack(8'h02, 4'd5);
      check("lvl_ack_irq", 32'(irq), 32'd0);
      wr(8'h02, 4'd6, 32'd0); hold(8'h02, 4'd0);
      check("lvl_eoi_irq", 32'(irq), 32'd1);
      repeat (3 + LX) hold('0, 4'd0);
      check("lvl_drop_irq", 32'(irq), 32'd0);

      // Edge source 2, one-cycle pulse
      wr('0, 4'd2, 32'h04);
      hold(8'h04, 4'd0); repeat (LX) hold('0, 4'd0);
      check("edge_pend", bus.dat_o, 32'h04);
      hold('0, 4'd0);
      check("edge_irq", 32'(irq), 32'd1);
      check("edge_id", 32'(int_id), 32'd2);
      ack('0, 4'd0);
      check("edge_ack_pend", bus.dat_o, 32'h00);
      wr('0, 4'd6, 32'd0); hold('0, 4'd0); hold('0, 4'd0);
      check("edge_eoi_irq", 32'(irq), 32'd0);

      // Preemption of source 5 by source 0
      wr('0, 4'd2, 32'h00);
      hold(8'h20, 4'd0); hold(8'h20, 4'd0); repeat (LX) hold(8'h20, 4'd0);
      check("pri_id5", 32'(int_id), 32'd5);
      hold(8'h21, 4'd0); hold(8'h21, 4'd0); repeat (LX) hold(8'h21, 4'd0);
      check("pri_id0", 32'(int_id), 32'd0);
      ack(8'h21, 4'd5);
      check("pri_vector", bus.dat_o, 32'h8000_0000);
      wr('0, 4'd6, 32'd0); repeat (4) hold('0, 4'd0);

      // Withdrawal by masking
      hold(8'h08, 4'd0); hold(8'h08, 4'd0); repeat (LX) hold(8'h08, 4'd0);
      check("wd_req_id", 32'(int_id), 32'd3);
      wr(8'h08, 4'd1, 32'h00); hold(8'h08, 4'd0);
      check("wd_irq", 32'(irq), 32'd0);
      ack(8'h08, 4'd5);
      check("wd_ack_irq", 32'(irq), 32'd0);
      check("wd_vector", bus.dat_o, 32'h0000_0003);

      // Edge set coincident with CLEAR of the same bit
      wr('0, 4'd2, 32'h40); hold('0, 4'd0);
      if (LX == 0) wr(8'h40, 4'd3, 32'h40);
      else begin hold(8'h40, 4'd0); hold('0, 4'd0); wr('0, 4'd3, 32'h40); end
      hold('0, 4'd0);
      check("simul_pend", bus.dat_o & 32'h40, 32'h40);
      wr('0, 4'd3, 32'hFF); wr('0, 4'd2, 32'h00); wr('0, 4'd1, 32'hFF);

      // Random traffic against the model
      cur_in = '0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) cur_in = N'($urandom);
         ra = 4'($urandom_range(0, 8));
         rd = $urandom;
         if (ra == 4'd4) rd = 32'($urandom_range(0, 3) != 0);
         step(cur_in, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 2) == 0), ra, rd);
      end

      // Asynchronous reset while a request is raised
      wr('0, 4'd2, 32'h00); wr('0, 4'd1, 32'hFF); wr('0, 4'd4, 32'h1);
      wr('0, 4'd6, 32'd0); repeat (3 + LX) hold('0, 4'd0);
      hold(8'h10, 4'd0); hold(8'h10, 4'd0); repeat (LX) hold(8'h10, 4'd0);
      check("pre_rst_irq", 32'(irq), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("async_rst_irq", 32'(irq), 32'd0);
      check("async_rst_id", 32'(int_id), 32'd0);
      m_reset();
      for (int a = 0; a < 7; a++) begin
         bus.add = 4'(a);
         #1 check("rst_reg", bus.dat_o, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) hold(8'h10, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
